saturating_drain: RTL

- Sequential counterpart to the saturating adder: holds an unsigned level register that is filled by saturating addition against a ceiling and drained by saturating subtraction against a floor.
- Each accepted drain request returns the amount actually removed through a registered valid/ready result stage.
- Used as a credit/token pool: upstream refills it and downstream consumers drain it.

---
 rtl/saturating_drain_pkg.sv | 25 ++
 rtl/saturating_drain_result_stage.sv | 34 +++
 rtl/saturating_drain.sv | 76 +++++++
 3 files changed

// File: rtl/saturating_drain_pkg.sv
// Shared definitions for the saturating level pool: default width and the
// saturating add/subtract helpers, evaluated one bit wider than any supported level.
package saturating_drain_pkg;

  localparam int WIDTH      = 8;
  localparam int CALC_WIDTH = 32;

  typedef logic [CALC_WIDTH-1:0] amount_t;
  typedef logic [CALC_WIDTH:0]   calc_t;

  // min(a + b, ceiling); the extra bit keeps the sum from wrapping.
  function automatic calc_t sat_add(input amount_t a, input amount_t b, input amount_t ceiling);
    calc_t sum;
    sum = calc_t'(a) + calc_t'(b);
    return (sum > calc_t'(ceiling)) ? calc_t'(ceiling) : sum;
  endfunction

  // a - b clamped at floor, but a value already below the floor is left alone.
  function automatic calc_t sat_sub(input amount_t a, input amount_t b, input amount_t floor);
    if (calc_t'(a) < calc_t'(floor)) return calc_t'(a);
    if (calc_t'(a) >= calc_t'(floor) + calc_t'(b)) return calc_t'(a) - calc_t'(b);
    return calc_t'(floor);
  endfunction

endpackage

// File: rtl/saturating_drain_result_stage.sv
// One-entry valid/ready register. A new entry may replace the current one in
// the same cycle it is consumed.
module result_stage #(
  parameter type data_t = logic
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  data_t push_data,
  output logic  ready,
  output logic  valid,
  output data_t data,
  input  logic  pop
);

  assign ready = !valid || pop;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      // NOTE: the payload is reset as well because it is directly observable
      // on the outputs, not just qualified by valid.
      data  <= '0;
    end else if (push && ready) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/saturating_drain.sv
// Credit/token pool: a level register filled with saturation at max_i and
// drained with saturation at min_i; each accepted drain reports what it removed.
module saturating_drain
  import saturating_drain_pkg::*;
#(
  parameter int               WIDTH = saturating_drain_pkg::WIDTH,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic [WIDTH-1:0] min_i,
  input  logic             fill_valid_i,
  input  logic [WIDTH-1:0] fill_amount_i,
  input  logic             drain_valid_i,
  input  logic [WIDTH-1:0] drain_amount_i,
  output logic             drain_ready_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [WIDTH-1:0] drained_o,
  output logic             clipped_o,
  output logic [WIDTH-1:0] level_o
);

  typedef struct packed {
    logic [WIDTH-1:0] drained;
    logic             clipped;
  } result_t;

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] filled;
  logic [WIDTH-1:0] drained_level;
  logic [WIDTH-1:0] removed;
  logic             drain_accept;
  result_t          next_result;
  result_t          result;

  assign drain_accept = drain_valid_i && drain_ready_o;

  // Fill is applied before drain when both arrive together.
  assign filled = fill_valid_i
                ? WIDTH'(sat_add(CALC_WIDTH'(level), CALC_WIDTH'(fill_amount_i), CALC_WIDTH'(max_i)))
                : level;

  assign drained_level = drain_accept
                       ? WIDTH'(sat_sub(CALC_WIDTH'(filled), CALC_WIDTH'(drain_amount_i), CALC_WIDTH'(min_i)))
                       : filled;

  // sat_sub never returns more than its input, so this cannot underflow.
  assign removed             = filled - drained_level;
  assign next_result.drained = removed;
  assign next_result.clipped = (removed != drain_amount_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) level <= INIT;
    else          level <= drained_level;
  end

  result_stage #(
    .data_t (result_t)
  ) u_result_stage (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (drain_valid_i),
    .push_data (next_result),
    .ready     (drain_ready_o),
    .valid     (result_valid_o),
    .data      (result),
    .pop       (result_ready_i)
  );

  assign level_o   = level;
  assign drained_o = result.drained;
  assign clipped_o = result.clipped;

endmodule
